rng_stat_checker: RTL and testbench

//  Consumer-side companion to the combined Tausworthe generator: takes its 32-bit word stream plus valid.

---
 rtl/rng_chk_pkg.sv | 46 ++++
 rtl/rng_word_stats.sv | 47 ++++
 rtl/rng_stat_checker.sv | 226 ++++++++++++++++++++++
 tb/tb_rng_stat_checker.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rng_chk_pkg.sv
// Shared types, constants and bit-statistics helpers for the RNG stream checker.
// The optional transition (runs) test is built when RNG_CHK_RUNS_EN is defined.
package rng_chk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_FLUSH = 3'd2,
        ST_EVAL  = 3'd3,
        ST_DONE  = 3'd4
    } chk_state_t;

    localparam int unsigned FLUSH_CYCLES = 32'd2;

    // Ceiling log2; returns the bit width needed to index 'value' distinct codes.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 32'd0;
        for (int unsigned i = 32'd0; i < 32'd32; i++) begin
            if ((value > 32'd1) && (((value - 32'd1) >> i) != 32'd0)) begin
                res = i + 32'd1;
            end
        end
        return res;
    endfunction

    function automatic logic [5:0] popcount32(input logic [31:0] word);
        logic [5:0] cnt;
        cnt = 6'd0;
        for (int i = 0; i < 32; i++) begin
            cnt = cnt + {5'd0, word[i]};
        end
        return cnt;
    endfunction

    // Number of adjacent bit pairs inside one word that differ (0..31).
    function automatic logic [4:0] trans_count32(input logic [31:0] word);
        logic [4:0] cnt;
        cnt = 5'd0;
        for (int i = 0; i < 31; i++) begin
            cnt = cnt + {4'd0, word[i] ^ word[i+1]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/rng_word_stats.sv
// First pipeline stage: registered popcount and intra-word transition count of one word.
// The transition counter exists only when RNG_CHK_RUNS_EN is defined.
module rng_word_stats
    import rng_chk_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        srst,
    input  logic        en,
    input  logic [31:0] word,
`ifdef RNG_CHK_RUNS_EN
    output logic [4:0]  trans,
`endif
    output logic [5:0]  pop
);

    logic [5:0] pop_r;
`ifdef RNG_CHK_RUNS_EN
    logic [4:0] trans_r;
`endif

    // Capture per-word statistics on every accepted word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pop_r   <= 6'd0;
`ifdef RNG_CHK_RUNS_EN
            trans_r <= 5'd0;
`endif
        end else if (srst) begin
            pop_r   <= 6'd0;
`ifdef RNG_CHK_RUNS_EN
            trans_r <= 5'd0;
`endif
        end else if (en) begin
            pop_r   <= popcount32(word);
`ifdef RNG_CHK_RUNS_EN
            trans_r <= trans_count32(word);
`endif
        end
    end

    assign pop   = pop_r;
`ifdef RNG_CHK_RUNS_EN
    assign trans = trans_r;
`endif

endmodule

// File: rtl/rng_stat_checker.sv
// Block-based monobit / runs statistics checker for a 32-bit RNG word stream.
// Define RNG_CHK_RUNS_EN to build the transition-count (runs) test; otherwise runs_pass is tied high.
module rng_stat_checker
    import rng_chk_pkg::*;
#(
    parameter  int unsigned BLOCK_WORDS = 32'd1024,
    parameter  int unsigned MONO_THRESH = 32'd600,
    parameter  int unsigned RUNS_THRESH = 32'd300,
    localparam int unsigned OW          = clog2(32'd32 * BLOCK_WORDS + 32'd1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [31:0]   in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          busy,
    output logic          done,
    output logic          mono_pass,
    output logic          runs_pass,
    output logic [OW-1:0] ones_cnt,
    output logic [OW-1:0] trans_cnt
);

    localparam int unsigned N_BITS = 32'd32 * BLOCK_WORDS;
    localparam int unsigned WCW    = clog2(BLOCK_WORDS + 32'd1);
    localparam int unsigned SW     = OW + 32'd2;

    localparam logic signed [SW-1:0] N_S      = SW'(N_BITS);
    localparam logic signed [SW-1:0] MONO_T_S = SW'(MONO_THRESH);

    chk_state_t           state_r;
    logic [WCW-1:0]       word_cnt_r;
    logic [1:0]           flush_cnt_r;
    logic                 in_ready_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 mono_r;
    logic [OW-1:0]        ones_acc_r;
    logic [OW-1:0]        ones_out_r;
    logic                 s1_valid_r;
    logic [5:0]           s1_pop_s;
    logic                 start_ok_s;
    logic                 accept_s;
    logic                 last_s;
    logic signed [SW-1:0] mono_diff_s;
    logic signed [SW-1:0] mono_abs_s;
    logic                 mono_ok_s;

`ifdef RNG_CHK_RUNS_EN
    localparam logic signed [SW-1:0] NM1_S     = SW'(N_BITS - 32'd1);
    localparam logic signed [SW-1:0] RUNS_T2_S = SW'(32'd2 * RUNS_THRESH);

    logic                 runs_r;
    logic [OW-1:0]        trans_acc_r;
    logic [OW-1:0]        trans_out_r;
    logic                 tx_r;
    logic                 prev_bit31_r;
    logic [4:0]           s1_trans_s;
    logic signed [SW-1:0] runs_diff_s;
    logic signed [SW-1:0] runs_abs_s;
    logic                 runs_ok_s;
`endif

    rng_word_stats u_word_stats (
        .clk   (clk),
        .rst   (rst),
        .srst  (start_ok_s),
        .en    (accept_s),
        .word  (in_data),
`ifdef RNG_CHK_RUNS_EN
        .trans (s1_trans_s),
`endif
        .pop   (s1_pop_s)
    );

    // Handshake qualification: start only counts while idle or finished
    always_comb begin
        accept_s = in_valid & in_ready_r;
        last_s   = accept_s && (word_cnt_r == WCW'(BLOCK_WORDS - 32'd1));
        if ((state_r == ST_IDLE) || (state_r == ST_DONE)) begin
            start_ok_s = start;
        end else begin
            start_ok_s = 1'b0;
        end
    end

    // Threshold comparisons; 2*count is formed by a left shift in signed OW+2 bits
    always_comb begin
        mono_diff_s = $signed({1'b0, ones_acc_r, 1'b0}) - N_S;
        if (mono_diff_s[SW-1]) begin
            mono_abs_s = -mono_diff_s;
        end else begin
            mono_abs_s = mono_diff_s;
        end
        mono_ok_s = (mono_abs_s <= MONO_T_S);
`ifdef RNG_CHK_RUNS_EN
        runs_diff_s = $signed({1'b0, trans_acc_r, 1'b0}) - NM1_S;
        if (runs_diff_s[SW-1]) begin
            runs_abs_s = -runs_diff_s;
        end else begin
            runs_abs_s = runs_diff_s;
        end
        runs_ok_s = (runs_abs_s <= RUNS_T2_S);
`endif
    end

    // Block control FSM with registered handshake, status and verdict outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            word_cnt_r  <= {WCW{1'b0}};
            flush_cnt_r <= 2'd0;
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            mono_r      <= 1'b0;
            ones_out_r  <= {OW{1'b0}};
`ifdef RNG_CHK_RUNS_EN
            runs_r      <= 1'b0;
            trans_out_r <= {OW{1'b0}};
`endif
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_r     <= ST_RUN;
                        word_cnt_r  <= {WCW{1'b0}};
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b1;
                        mono_r      <= 1'b0;
                        ones_out_r  <= {OW{1'b0}};
`ifdef RNG_CHK_RUNS_EN
                        runs_r      <= 1'b0;
                        trans_out_r <= {OW{1'b0}};
`endif
                    end
                end
                ST_RUN: begin
                    if (accept_s) begin
                        word_cnt_r <= word_cnt_r + WCW'(32'd1);
                        if (last_s) begin
                            in_ready_r  <= 1'b0;
                            flush_cnt_r <= 2'd0;
                            state_r     <= ST_FLUSH;
                        end
                    end
                end
                // Lets the last word drain through S1 and S2 before evaluation
                ST_FLUSH: begin
                    flush_cnt_r <= flush_cnt_r + 2'd1;
                    if (flush_cnt_r == 2'(FLUSH_CYCLES - 32'd1)) begin
                        state_r <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    mono_r      <= mono_ok_s;
                    ones_out_r  <= ones_acc_r;
`ifdef RNG_CHK_RUNS_EN
                    runs_r      <= runs_ok_s;
                    trans_out_r <= trans_acc_r;
`endif
                    done_r      <= 1'b1;
                    busy_r      <= 1'b0;
                    state_r     <= ST_DONE;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    in_ready_r <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    // S2 accumulators plus the word-boundary transition bit captured alongside S1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_r   <= 1'b0;
            ones_acc_r   <= {OW{1'b0}};
`ifdef RNG_CHK_RUNS_EN
            trans_acc_r  <= {OW{1'b0}};
            tx_r         <= 1'b0;
            prev_bit31_r <= 1'b0;
`endif
        end else if (start_ok_s) begin
            s1_valid_r   <= 1'b0;
            ones_acc_r   <= {OW{1'b0}};
`ifdef RNG_CHK_RUNS_EN
            trans_acc_r  <= {OW{1'b0}};
            tx_r         <= 1'b0;
            prev_bit31_r <= 1'b0;
`endif
        end else begin
            s1_valid_r <= accept_s;
            if (s1_valid_r) begin
                ones_acc_r  <= ones_acc_r + OW'(s1_pop_s);
`ifdef RNG_CHK_RUNS_EN
                trans_acc_r <= trans_acc_r + OW'(s1_trans_s) + OW'(tx_r);
`endif
            end
`ifdef RNG_CHK_RUNS_EN
            if (accept_s) begin
                // The first word of a block has no predecessor to transition from
                tx_r         <= (word_cnt_r != {WCW{1'b0}}) & (in_data[0] ^ prev_bit31_r);
                prev_bit31_r <= in_data[31];
            end
`endif
        end
    end

    assign in_ready  = in_ready_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign mono_pass = mono_r;
    assign ones_cnt  = ones_out_r;
`ifdef RNG_CHK_RUNS_EN
    assign runs_pass = runs_r;
    assign trans_cnt = trans_out_r;
`else
    assign runs_pass = 1'b1;
    assign trans_cnt = {OW{1'b0}};
`endif

endmodule

// File: tb/tb_rng_stat_checker.sv
// Directed table-driven bench for rng_stat_checker (4-word blocks) plus a
// default-size block fed by a three-part Tausworthe generator.
module tb_rng_stat_checker;

`ifdef RNG_CHK_RUNS_EN
    localparam bit RUNS_EN = 1'b1;
`else
    localparam bit RUNS_EN = 1'b0;
`endif

    typedef struct packed {
        logic [3:0][31:0] words;
        logic             gap;
        logic             start_mid;
        logic [7:0]       ones;
        logic [7:0]       trans;
        logic             mono;
        logic             runs;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        start_a = 1'b0;
    logic [31:0] data_a  = 32'd0;
    logic        valid_a = 1'b0;
    logic        ready_a, busy_a, done_a, mono_a, runs_a;
    logic [7:0]  ones_a, trans_a;

    logic        start_b = 1'b0;
    logic [31:0] data_b  = 32'd0;
    logic        valid_b = 1'b0;
    logic        ready_b, busy_b, done_b, mono_b, runs_b;
    logic [15:0] ones_b, trans_b;

    int checks = 0;
    int errors = 0;

    vec_t vecs [8];
    logic [31:0] s1, s2, s3;

    rng_stat_checker #(.BLOCK_WORDS(4), .MONO_THRESH(20), .RUNS_THRESH(10)) dut (
        .clk(clk), .rst(rst), .start(start_a), .in_data(data_a), .in_valid(valid_a),
        .in_ready(ready_a), .busy(busy_a), .done(done_a), .mono_pass(mono_a),
        .runs_pass(runs_a), .ones_cnt(ones_a), .trans_cnt(trans_a)
    );

    rng_stat_checker dut_big (
        .clk(clk), .rst(rst), .start(start_b), .in_data(data_b), .in_valid(valid_b),
        .in_ready(ready_b), .busy(busy_b), .done(done_b), .mono_pass(mono_b),
        .runs_pass(runs_b), .ones_cnt(ones_b), .trans_cnt(trans_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic set_vec(input int idx, input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3, input logic gap,
                           input logic smid, input logic [7:0] ones, input logic [7:0] trans,
                           input logic mono, input logic runs);
        vecs[idx].words     = {w3, w2, w1, w0};
        vecs[idx].gap       = gap;
        vecs[idx].start_mid = smid;
        vecs[idx].ones      = ones;
        vecs[idx].trans     = trans;
        vecs[idx].mono      = mono;
        vecs[idx].runs      = runs;
    endtask

    task automatic next_taus(output logic [31:0] w);
        logic [31:0] b;
        b  = ((s1 << 13) ^ s1) >> 19;
        s1 = ((s1 & 32'hFFFF_FFFE) << 12) ^ b;
        b  = ((s2 << 2) ^ s2) >> 25;
        s2 = ((s2 & 32'hFFFF_FFF8) << 4) ^ b;
        b  = ((s3 << 3) ^ s3) >> 11;
        s3 = ((s3 & 32'hFFFF_FFF0) << 17) ^ b;
        w  = s1 ^ s2 ^ s3;
    endtask

    task automatic run_block(input vec_t v, input int tag);
        int   idx;
        int   cyc;
        int   lat;
        logic acc;
        @(posedge clk); #1;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < 4 && cyc < 40) begin
            data_a  = v.words[idx];
            valid_a = v.gap ? (cyc[0] == 1'b0) : 1'b1;
            start_a = v.start_mid && (idx == 2);
            @(negedge clk);
            acc = valid_a & ready_a;
            if (cyc == 0) check($sformatf("v%0d_busy_run", tag), {31'd0, busy_a}, 32'd1);
            @(posedge clk); #1;
            if (acc) idx++;
            cyc++;
        end
        valid_a = 1'b0;
        start_a = 1'b0;
        check($sformatf("v%0d_accepted", tag), idx, 32'd4);
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat == 1) check($sformatf("v%0d_ready_drop", tag), {31'd0, ready_a}, 32'd0);
            if (done_a) break;
        end
        check($sformatf("v%0d_done_latency", tag), lat, 32'd4);
        check($sformatf("v%0d_ones", tag), {24'd0, ones_a}, {24'd0, v.ones});
        check($sformatf("v%0d_trans", tag), {24'd0, trans_a}, RUNS_EN ? {24'd0, v.trans} : 32'd0);
        check($sformatf("v%0d_mono", tag), {31'd0, mono_a}, {31'd0, v.mono});
        check($sformatf("v%0d_runs", tag), {31'd0, runs_a}, RUNS_EN ? {31'd0, v.runs} : 32'd1);
        check($sformatf("v%0d_busy_done", tag), {31'd0, busy_a}, 32'd0);
        @(negedge clk);
        check($sformatf("v%0d_done_pulse", tag), {31'd0, done_a}, 32'd0);
        check($sformatf("v%0d_mono_hold", tag), {31'd0, mono_a}, {31'd0, v.mono});
    endtask

    initial begin
        int   cnt;
        int   idx;
        int   lat;
        int   m_ones;
        int   m_trans;
        int   m_diff;
        logic have_prev;
        logic prev_bit;
        logic acc;
        logic [31:0] w;

        set_vec(0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 8'd0,  8'd0,   1'b0, 1'b0);
        set_vec(1, 32'h5555_5555, 32'h5555_5555, 32'h5555_5555, 32'h5555_5555, 1'b0, 1'b0, 8'd64, 8'd127, 1'b1, 1'b0);
        set_vec(2, 32'h0000_FFFF, 32'hFFFF_0000, 32'h0000_FFFF, 32'hFFFF_0000, 1'b0, 1'b0, 8'd64, 8'd4,   1'b1, 1'b0);
        set_vec(3, 32'h5555_5555, 32'h5555_5555, 32'h5555_5555, 32'h5555_5555, 1'b1, 1'b1, 8'd64, 8'd127, 1'b1, 1'b0);
        set_vec(4, 32'hFFFF_FFFF, 32'h003F_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 8'd54, 8'd1,   1'b1, 1'b0);
        set_vec(5, 32'hFFFF_FFFF, 32'h001F_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 8'd53, 8'd1,   1'b0, 1'b0);
        set_vec(6, 32'h5555_5555, 32'h0000_0000, 32'h0015_5555, 32'hFFFF_FFFF, 1'b0, 1'b0, 8'd59, 8'd54,  1'b1, 1'b1);
        set_vec(7, 32'h5555_5555, 32'h0000_0000, 32'h0015_5555, 32'h0000_0000, 1'b0, 1'b0, 8'd27, 8'd53,  1'b0, 1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'd0, ready_a}, 32'd0);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_done", {31'd0, done_a}, 32'd0);
        check("rst_mono", {31'd0, mono_a}, 32'd0);
        check("rst_runs", {31'd0, runs_a}, RUNS_EN ? 32'd0 : 32'd1);
        check("rst_ones", {24'd0, ones_a}, 32'd0);
        check("rst_trans", {24'd0, trans_a}, 32'd0);
        check("rst_big_ready", {31'd0, ready_b}, 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_block(vecs[i], i);
        end

        // Reset in the middle of a block
        @(posedge clk); #1;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        data_a  = 32'h5555_5555;
        valid_a = 1'b1;
        @(posedge clk);
        @(posedge clk); #2;
        check("mid_busy_before", {31'd0, busy_a}, 32'd1);
        rst = 1'b0;
        #1;
        check("mid_ready", {31'd0, ready_a}, 32'd0);
        check("mid_busy", {31'd0, busy_a}, 32'd0);
        check("mid_ones", {24'd0, ones_a}, 32'd0);
        check("mid_trans", {24'd0, trans_a}, 32'd0);
        check("mid_done", {31'd0, done_a}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done_a || ready_a) cnt++;
        end
        check("mid_no_done_no_ready", cnt, 32'd0);
        valid_a = 1'b0;
        run_block(vecs[1], 10);

        // Default-size block fed by the Tausworthe generator
        s1 = 32'd12345;
        s2 = 32'd67890;
        s3 = 32'd13579;
        @(posedge clk); #1;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        idx = 0;
        cnt = 0;
        m_ones = 0;
        m_trans = 0;
        have_prev = 1'b0;
        prev_bit = 1'b0;
        while (idx < 1024 && cnt < 1200) begin
            next_taus(w);
            data_b  = w;
            valid_b = 1'b1;
            @(negedge clk);
            acc = ready_b;
            if (acc) begin
                for (int b = 0; b < 32; b++) begin
                    m_ones += int'(w[b]);
                    if (have_prev && (w[b] != prev_bit)) m_trans++;
                    prev_bit  = w[b];
                    have_prev = 1'b1;
                end
                idx++;
            end
            @(posedge clk); #1;
            cnt++;
        end
        valid_b = 1'b0;
        check("big_accepted", idx, 32'd1024);
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (done_b) break;
        end
        check("big_done_latency", lat, 32'd4);
        check("big_ones", {16'd0, ones_b}, m_ones);
        check("big_trans", {16'd0, trans_b}, RUNS_EN ? m_trans : 32'd0);
        m_diff = 2 * m_ones - 32768;
        if (m_diff < 0) m_diff = -m_diff;
        check("big_mono", {31'd0, mono_b}, (m_diff <= 600) ? 32'd1 : 32'd0);
        m_diff = 2 * m_trans - 32767;
        if (m_diff < 0) m_diff = -m_diff;
        check("big_runs", {31'd0, runs_b}, (!RUNS_EN || m_diff <= 600) ? 32'd1 : 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
